axi_lite_arbiter: RTL and testbench

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

---
 rtl/arb_pkg.sv | 32 +++
 rtl/arb_pick.sv | 29 ++
 rtl/axi_lite_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the AXI-lite SRAM arbiter.
// Supplies default AXI-lite bus widths when the surrounding build has not defined them.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS [31:0]
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS [31:0]
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS [1:0]
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS [3:0]
`endif

package arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIfuRd,
        StLsuRd,
        StLsuWr
    } arb_state_e;

    typedef enum logic {
        MstIfu = 1'b0,
        MstLsu = 1'b1
    } master_id_e;

    localparam logic [15:0] BusyCntMax = 16'hFFFF;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between IFU and LSU requests; purely combinational.
// ARB_RR_EN selects round-robin on conflict, otherwise LSU has fixed priority.
module arb_pick
    import arb_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
`ifdef ARB_RR_EN
    input  master_id_e last_grant,
`endif
    output logic       grant_valid,
    output master_id_e winner
);

    always_comb begin
        grant_valid = ifu_req | lsu_req;
        winner      = MstIfu;
        if (ifu_req && lsu_req) begin
`ifdef ARB_RR_EN
            winner = (last_grant == MstIfu) ? MstLsu : MstIfu;
`else
            winner = MstLsu;
`endif
        end else if (lsu_req) begin
            winner = MstLsu;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Grants the shared data SRAM to one IFU or LSU AXI-lite transaction at a time.
// Define ARB_RR_EN for round-robin on IFU/LSU conflicts; default build is fixed LSU priority.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS [31:0]
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS [31:0]
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS [1:0]
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS [3:0]
`endif

module axi_lite_arbiter
    import arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic `AXI_ADDR_BUS    ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic `AXI_DATA_BUS    ifu_rdata,
    output logic `AXI_RESP_BUS    ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    input  logic `AXI_ADDR_BUS    lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic `AXI_DATA_BUS    lsu_rdata,
    output logic `AXI_RESP_BUS    lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    input  logic `AXI_ADDR_BUS    lsu_awaddr,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic `AXI_DATA_BUS    lsu_wdata,
    input  logic `AXI_WSTRB_BUS   lsu_wstrb,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    output logic `AXI_RESP_BUS    lsu_bresp,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic `AXI_ADDR_BUS    mem_araddr,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic `AXI_DATA_BUS    mem_rdata,
    input  logic `AXI_RESP_BUS    mem_rresp,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    output logic `AXI_ADDR_BUS    mem_awaddr,
    output logic                  mem_awvalid,
    input  logic                  mem_awready,
    output logic `AXI_DATA_BUS    mem_wdata,
    output logic `AXI_WSTRB_BUS   mem_wstrb,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    input  logic `AXI_RESP_BUS    mem_bresp,
    input  logic                  mem_bvalid,
    output logic                  mem_bready,
    output logic [15:0]           arb_busy_cnt
);

    arb_state_e  state_q;
    logic [15:0] busy_cnt_q;
    logic        grant_valid;
    master_id_e  winner;
    logic        txn_done;
`ifdef ARB_RR_EN
    master_id_e  last_grant_q;
`endif

    arb_pick u_arb_pick (
        .ifu_req     (ifu_arvalid),
        .lsu_req     (lsu_arvalid | lsu_awvalid),
`ifdef ARB_RR_EN
        .last_grant  (last_grant_q),
`endif
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // Only the final R or B handshake releases a grant; dropped valids are ignored.
    assign txn_done = (state_q == StLsuWr) ? (mem_bvalid & mem_bready)
                                           : (mem_rvalid & mem_rready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            busy_cnt_q <= '0;
`ifdef ARB_RR_EN
            last_grant_q <= MstIfu;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_cnt_q <= '0;
                    if (grant_valid) begin
                        busy_cnt_q <= 16'd1;
                        if (winner == MstIfu) begin
                            state_q <= StIfuRd;
                        end else if (lsu_awvalid) begin
                            state_q <= StLsuWr;
                        end else begin
                            state_q <= StLsuRd;
                        end
`ifdef ARB_RR_EN
                        last_grant_q <= winner;
`endif
                    end
                end
                StIfuRd, StLsuRd, StLsuWr: begin
                    if (txn_done) begin
                        state_q    <= StIdle;
                        busy_cnt_q <= '0;
                    end else if (busy_cnt_q != BusyCntMax) begin
                        busy_cnt_q <= busy_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign arb_busy_cnt = busy_cnt_q;

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StIfuRd: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
            end
            StLsuRd: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
            end
            StLsuWr: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid;
                lsu_awready = mem_awready;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid;
                lsu_wready  = mem_wready;
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a small SRAM responder on the mem_* side.
// Expectations follow the build: ARB_RR_EN selects the round-robin conflict outcome.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS [31:0]
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS [31:0]
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS [1:0]
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS [3:0]
`endif

module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic `AXI_ADDR_BUS  ifu_araddr;
    logic                ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic `AXI_DATA_BUS  ifu_rdata;
    logic `AXI_RESP_BUS  ifu_rresp;
    logic `AXI_ADDR_BUS  lsu_araddr, lsu_awaddr;
    logic                lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic `AXI_DATA_BUS  lsu_rdata, lsu_wdata;
    logic `AXI_RESP_BUS  lsu_rresp, lsu_bresp;
    logic `AXI_WSTRB_BUS lsu_wstrb;
    logic                lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic                lsu_bvalid, lsu_bready;
    logic `AXI_ADDR_BUS  mem_araddr, mem_awaddr;
    logic                mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic `AXI_DATA_BUS  mem_rdata, mem_wdata;
    logic `AXI_RESP_BUS  mem_rresp, mem_bresp;
    logic `AXI_WSTRB_BUS mem_wstrb;
    logic                mem_awvalid, mem_awready, mem_wvalid, mem_wready;
    logic                mem_bvalid, mem_bready;
    logic [15:0]         arb_busy_cnt;

    int n_chk = 0;
    int n_fail = 0;

    axi_lite_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
        .lsu_bready(lsu_bready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid),
        .mem_bready(mem_bready),
        .arb_busy_cnt(arb_busy_cnt)
    );

    // SRAM responder: always ready; R one cycle after AR, B one cycle after both AW and W.
    logic [31:0]   sram [0:4095];
    logic [4095:0] sram_wr;
    logic          aw_got, w_got;
    logic [31:0]   aw_addr_q, w_data_q, last_wr_addr, last_wr_data;
    logic [3:0]    w_strb_q, last_wr_strb;

    assign mem_arready = 1'b1;
    assign mem_awready = 1'b1;
    assign mem_wready  = 1'b1;
    assign mem_rresp   = 2'b00;
    assign mem_bresp   = 2'b00;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid   <= 1'b0;
            mem_rdata    <= '0;
            mem_bvalid   <= 1'b0;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            last_wr_addr <= '0;
            last_wr_data <= '0;
            last_wr_strb <= '0;
            sram_wr      <= '0;
        end else begin
            if (mem_rvalid && mem_rready) mem_rvalid <= 1'b0;
            if (mem_arvalid) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= sram_wr[mem_araddr[13:2]] ? sram[mem_araddr[13:2]]
                                                        : fill(mem_araddr);
            end
            if (mem_awvalid) begin
                aw_got    <= 1'b1;
                aw_addr_q <= mem_awaddr;
            end
            if (mem_wvalid) begin
                w_got    <= 1'b1;
                w_data_q <= mem_wdata;
                w_strb_q <= mem_wstrb;
            end
            if (aw_got && w_got) begin
                sram[aw_addr_q[13:2]] <= merge(sram_wr[aw_addr_q[13:2]] ? sram[aw_addr_q[13:2]]
                                               : fill(aw_addr_q), w_data_q, w_strb_q);
                sram_wr[aw_addr_q[13:2]] <= 1'b1;
                last_wr_addr <= aw_addr_q;
                last_wr_data <= w_data_q;
                last_wr_strb <= w_strb_q;
                mem_bvalid   <= 1'b1;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end
            if (mem_bvalid && mem_bready) mem_bvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs a granted read to R completion, dropping arvalid after its handshake.
    task automatic read_wait(input bit is_lsu, input logic [31:0] exp, input string tag);
        bit done;
        bit ar_hs;
        bit r_hs;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            ar_hs = is_lsu ? (lsu_arvalid && lsu_arready) : (ifu_arvalid && ifu_arready);
            r_hs  = is_lsu ? (lsu_rvalid && lsu_rready) : (ifu_rvalid && ifu_rready);
            if (r_hs) begin
                chk({tag, " rdata"}, is_lsu ? lsu_rdata : ifu_rdata, exp);
                done = 1'b1;
            end
            tick();
            if (ar_hs) begin
                if (is_lsu) lsu_arvalid = 1'b0;
                else ifu_arvalid = 1'b0;
            end
            settle();
        end
        chk({tag, " completed"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        rst_n = 1'b0;

        // Request held through reset must not leak out while reset is low
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst ifu_arready", ifu_arready, 0);
        chk("rst mem_arvalid", mem_arvalid, 0);
        chk("rst mem_awvalid", mem_awvalid, 0);
        chk("rst mem_wvalid", mem_wvalid, 0);
        chk("rst ifu_rdata", ifu_rdata, 0);
        chk("rst busy_cnt", arb_busy_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release mem_arvalid", mem_arvalid, 0);

        // IFU read
        tick(); settle();
        chk("ifu mem_arvalid", mem_arvalid, 1);
        chk("ifu mem_araddr", mem_araddr, 32'h8000_0000);
        chk("ifu busy_cnt", arb_busy_cnt, 1);
        chk("ifu lsu_arready", lsu_arready, 0);
        read_wait(1'b0, 32'hDA5A_0000, "ifu read");
        chk("ifu idle arready", ifu_arready, 0);
        chk("ifu idle busy_cnt", arb_busy_cnt, 0);

        // LSU write while IFU also requests
        lsu_awaddr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_bready = 1'b1;
        ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
        tick(); settle();
        chk("wr mem_awvalid", mem_awvalid, 1);
        chk("wr mem_awaddr", mem_awaddr, 32'h8000_1000);
        chk("wr mem_wvalid", mem_wvalid, 1);
        chk("wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("wr mem_wstrb", mem_wstrb, 4'hF);
        chk("wr lsu_awready", lsu_awready, 1);
        chk("wr ifu_arready", ifu_arready, 0);
        chk("wr mem_arvalid", mem_arvalid, 0);
        tick(); lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; settle();
        chk("wr ifu blocked 2", ifu_arready, 0);
        tick(); settle();
        chk("wr lsu_bvalid", lsu_bvalid, 1);
        chk("wr lsu_bresp", lsu_bresp, 0);
        chk("wr sram addr", last_wr_addr, 32'h8000_1000);
        chk("wr sram data", last_wr_data, 32'hDEAD_BEEF);
        chk("wr sram strb", last_wr_strb, 4'hF);
        chk("wr ifu blocked 3", ifu_arready, 0);
        tick(); settle();
        chk("wr lsu_bvalid once", lsu_bvalid, 0);
        chk("wr idle ifu_arready", ifu_arready, 0);
        tick(); settle();
        chk("ifu after wr mem_araddr", mem_araddr, 32'h8000_0100);
        read_wait(1'b0, 32'hDA5A_0100, "ifu after wr");

        // Simultaneous LSU write and read: write first
        lsu_awaddr = 32'h8000_2000; lsu_araddr = 32'h8000_2000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        tick(); settle();
        chk("wr-rd first awvalid", mem_awvalid, 1);
        chk("wr-rd first arvalid", mem_arvalid, 0);
        chk("wr-rd lsu_arready", lsu_arready, 0);
        tick(); lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; settle();
        tick(); settle();
        chk("wr-rd bvalid", lsu_bvalid, 1);
        tick(); settle();
        chk("wr-rd idle arvalid", mem_arvalid, 0);
        tick(); settle();
        chk("wr-rd read arvalid", mem_arvalid, 1);
        chk("wr-rd read araddr", mem_araddr, 32'h8000_2000);
        read_wait(1'b1, 32'hDEAD_BEEF, "wr-rd read");

        // IFU/LSU read conflict from reset state, then LSU re-requests
        do_reset();
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
        lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        tick(); settle();
        chk("conflict1 winner addr", mem_araddr, 32'h8000_2000);
        chk("conflict1 ifu_arready", ifu_arready, 0);
        read_wait(1'b1, 32'hDA5A_2000, "conflict1 lsu");
        lsu_araddr = 32'h8000_3000; lsu_arvalid = 1'b1;
        tick(); settle();
`ifdef ARB_RR_EN
        chk("conflict2 winner addr", mem_araddr, 32'h8000_0000);
        read_wait(1'b0, 32'hDA5A_0000, "conflict2 ifu");
        tick(); settle();
        chk("conflict2 loser addr", mem_araddr, 32'h8000_3000);
        read_wait(1'b1, 32'hDA5A_3000, "conflict2 lsu");
`else
        chk("conflict2 winner addr", mem_araddr, 32'h8000_3000);
        read_wait(1'b1, 32'hDA5A_3000, "conflict2 lsu");
        tick(); settle();
        chk("conflict2 loser addr", mem_araddr, 32'h8000_0000);
        read_wait(1'b0, 32'hDA5A_0000, "conflict2 ifu");
`endif

        // Reset while an LSU read waits on rready
        lsu_araddr = 32'h8000_0040; lsu_arvalid = 1'b1; lsu_rready = 1'b0;
        tick(); settle();
        tick(); lsu_arvalid = 1'b0; settle();
        tick(); settle();
        chk("stall lsu_rvalid", lsu_rvalid, 1);
        chk("stall lsu_rdata", lsu_rdata, 32'hDA5A_0040);
        chk("stall busy_cnt", arb_busy_cnt, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst lsu_rvalid", lsu_rvalid, 0);
        chk("midrst lsu_rdata", lsu_rdata, 0);
        chk("midrst mem_arvalid", mem_arvalid, 0);
        chk("midrst mem_rready", mem_rready, 0);
        chk("midrst busy_cnt", arb_busy_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lsu_rready = 1'b1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        #1;
        chk("postrst mem_arvalid", mem_arvalid, 0);
        tick(); settle();
        chk("postrst ifu araddr", mem_araddr, 32'h8000_0000);
        read_wait(1'b0, 32'hDA5A_0000, "postrst ifu");
        chk("postrst busy_cnt", arb_busy_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
